// File: rtl/cart_ram_arbiter_pkg.sv
// Shared types and defaults for the cartridge save-RAM arbiter.
package cart_ram_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } host_state_t;

    localparam int unsigned DEFAULT_IDLE_CYCLES = 1048576;

endpackage

// File: rtl/cart_ram_arbiter_save_idle_timer.sv
// Dirty flag plus quiet-period counter; pulses save_req once per burst of Game Boy writes.
module save_idle_timer #(
    parameter int unsigned IDLE_CYCLES = 1048576,
    parameter int unsigned TW          = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic gb_write,
    input  logic save_clr,
    output logic dirty,
    output logic save_req
);

    localparam logic [TW-1:0] LIMIT = TW'(IDLE_CYCLES);

    logic [TW-1:0] timer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dirty    <= 1'b0;
            timer    <= '0;
            save_req <= 1'b0;
        end else begin
            save_req <= 1'b0;
            if (gb_write) begin
                // a write in the same cycle as save_clr keeps the data marked unsaved
                dirty <= 1'b1;
                timer <= '0;
            end else if (save_clr) begin
                dirty <= 1'b0;
                timer <= '0;
            end else if (dirty && (timer < LIMIT)) begin
                timer <= timer + 1'b1;
                if (timer == LIMIT - 1'b1) begin
                    save_req <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cart_ram_arbiter.sv
// Single-port save-RAM arbiter: Game Boy always wins, host uses idle cycles.
module cart_ram_arbiter
    import cart_ram_arbiter_pkg::*;
#(
    parameter int unsigned ABITS       = 15,
    parameter int unsigned IDLE_CYCLES = DEFAULT_IDLE_CYCLES,
    parameter int unsigned TW          = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gb_ram_cs_n,
    input  logic             gb_rd,
    input  logic             gb_wr,
    input  logic [ABITS-1:0] gb_addr,
    input  logic [7:0]       gb_wdata,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [ABITS-1:0] host_addr,
    input  logic [7:0]       host_wdata,
    output logic             host_ack,
    output logic [7:0]       host_rdata,
    input  logic             save_clr,
    output logic             dirty,
    output logic             save_req,
    output logic [ABITS-1:0] ram_addr,
    output logic [7:0]       ram_din,
    output logic             ram_we,
    input  logic [7:0]       ram_dout
);

    host_state_t state, state_next;
    logic        gb_act;
    logic        host_issue;
    logic        ack_hold;
    logic [7:0]  rdata_q;

    assign gb_act = !gb_ram_cs_n && (gb_rd || gb_wr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ack_hold <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state    <= state_next;
            ack_hold <= (state == ST_WAIT);
            if ((state == ST_WAIT) && !host_we) begin
                rdata_q <= ram_dout;
            end
        end
    end

    always_comb begin
        state_next = state;
        host_issue = 1'b0;
        ram_addr   = host_addr;
        ram_din    = host_wdata;
        ram_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                host_issue = host_req && !gb_act && !ack_hold;
                if (host_issue) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (gb_act) begin
            ram_addr = gb_addr;
            ram_din  = gb_wdata;
            ram_we   = gb_wr;
        end else if (host_issue) begin
            ram_we = host_we;
        end
    end

    assign host_ack = (state == ST_WAIT);
    // read data is forwarded straight from the RAM during the ack cycle, then held
    assign host_rdata = ((state == ST_WAIT) && !host_we) ? ram_dout : rdata_q;

    save_idle_timer #(
        .IDLE_CYCLES(IDLE_CYCLES),
        .TW         (TW)
    ) u_save_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .gb_write(gb_act && gb_wr),
        .save_clr(save_clr),
        .dirty   (dirty),
        .save_req(save_req)
    );

endmodule

// File: tb/tb_cart_ram_arbiter.sv
// Scoreboard bench for cart_ram_arbiter with a behavioural synchronous RAM.
module tb_cart_ram_arbiter;

    localparam int unsigned ABITS = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             gb_ram_cs_n = 1'b1;
    logic             gb_rd = 1'b0;
    logic             gb_wr = 1'b0;
    logic [ABITS-1:0] gb_addr = '0;
    logic [7:0]       gb_wdata = '0;
    logic             host_req = 1'b0;
    logic             host_we = 1'b0;
    logic [ABITS-1:0] host_addr = '0;
    logic [7:0]       host_wdata = '0;
    logic             host_ack;
    logic [7:0]       host_rdata;
    logic             save_clr = 1'b0;
    logic             dirty;
    logic             save_req;
    logic [ABITS-1:0] ram_addr;
    logic [7:0]       ram_din;
    logic             ram_we;
    logic [7:0]       ram_dout = '0;

    logic [7:0] mem [0:(1<<ABITS)-1];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pulses = 0;
    logic [7:0] last_read = '0;
    logic [7:0] host_q[$];
    int         save_q[$];
    logic req_prev = 1'b0;
    logic ack_prev = 1'b0;

    cart_ram_arbiter #(
        .ABITS      (ABITS),
        .IDLE_CYCLES(8),
        .TW         (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gb_ram_cs_n(gb_ram_cs_n),
        .gb_rd      (gb_rd),
        .gb_wr      (gb_wr),
        .gb_addr    (gb_addr),
        .gb_wdata   (gb_wdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .save_clr   (save_clr),
        .dirty      (dirty),
        .save_req   (save_req),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // host response monitor
    always @(negedge clk) begin
        if (!rst && host_ack) begin
            tests++;
            if (host_q.size() == 0) begin
                fails++;
                $display("FAIL host_ack_unexpected: got ack with rdata 0x%0h, expected no ack", host_rdata);
            end else begin
                logic [7:0] e;
                e = host_q.pop_front();
                if (host_rdata !== e) begin
                    fails++;
                    $display("FAIL host_rdata: got 0x%0h expected 0x%0h", host_rdata, e);
                end
            end
        end
    end

    // save_req monitor
    always @(negedge clk) begin
        if (!rst && save_req) begin
            pulses++;
            tests++;
            if (save_q.size() == 0) begin
                fails++;
                $display("FAIL save_req_unexpected: pulse at cycle %0d, expected none", cyc);
            end else begin
                int e;
                e = save_q.pop_front();
                if (cyc != e) begin
                    fails++;
                    $display("FAIL save_req_cycle: got cycle %0d expected %0d", cyc, e);
                end
            end
        end
    end

    // host protocol: host_req must stay high until acked
    always @(negedge clk) begin
        if (!rst && req_prev && !ack_prev && !host_req) begin
            fails++;
            $display("FAIL host_req_drop: got req low before ack, expected held");
        end
        req_prev <= rst ? 1'b0 : host_req;
        ack_prev <= host_ack;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_start(input logic we, input logic [ABITS-1:0] a, input logic [7:0] wd,
                              input logic [7:0] exp_rd, input logic push);
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = wd;
        if (push) begin
            if (!we) last_read = exp_rd;
            host_q.push_back(last_read);
        end
    endtask

    task automatic host_finish(input int exp_cyc);
        int got;
        got = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (host_ack) begin
                got = cyc;
                break;
            end
        end
        chk("host_ack_cycle", 32'(got), 32'(exp_cyc));
        tick();
        host_req = 1'b0;
    endtask

    task automatic gb_set(input logic rd, input logic wr, input logic [ABITS-1:0] a, input logic [7:0] d);
        gb_ram_cs_n = !(rd || wr);
        gb_rd       = rd;
        gb_wr       = wr;
        gb_addr     = a;
        gb_wdata    = d;
    endtask

    initial begin
        int n;
        int p0;
        for (int i = 0; i < (1 << ABITS); i++) mem[i] = 8'h00;
        mem[15'h0123] = 8'hA5;

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ack", 32'(host_ack), 32'd0);
        chk("reset_rdata", 32'(host_rdata), 32'd0);
        chk("reset_dirty", 32'(dirty), 32'd0);
        chk("reset_save_req", 32'(save_req), 32'd0);
        chk("reset_ram_we", 32'(ram_we), 32'd0);

        // uncontended host read
        tick(); n = cyc;
        host_start(1'b0, 15'h0123, 8'h00, 8'hA5, 1'b1);
        @(negedge clk);
        chk("rd_ram_we", 32'(ram_we), 32'd0);
        chk("rd_ram_addr", 32'(ram_addr), 32'h0123);
        host_finish(n + 1);

        // host write held off by four Game Boy reads
        tick(); n = cyc;
        gb_set(1'b1, 1'b0, 15'h0123, 8'h00);
        host_start(1'b1, 15'h0040, 8'h5A, 8'h00, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("cont_ram_we", 32'(ram_we), 32'd0);
            chk("cont_ram_addr", 32'(ram_addr), 32'h0123);
            if (k > 0) chk("cont_gb_rdata", 32'(ram_dout), 32'hA5);
            tick();
        end
        gb_set(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("cont_gb_rdata_last", 32'(ram_dout), 32'hA5);
        chk("cont_host_we", 32'(ram_we), 32'd1);
        chk("cont_host_addr", 32'(ram_addr), 32'h0040);
        chk("cont_host_din", 32'(ram_din), 32'h5A);
        host_finish(n + 5);
        tick(); n = cyc;
        host_start(1'b0, 15'h0040, 8'h00, 8'h5A, 1'b1);
        host_finish(n + 1);

        // Game Boy write beats a same-cycle host write
        tick(); n = cyc;
        gb_set(1'b0, 1'b1, 15'h0010, 8'h11);
        host_start(1'b1, 15'h0010, 8'h22, 8'h00, 1'b1);
        @(negedge clk);
        chk("prio_ram_we", 32'(ram_we), 32'd1);
        chk("prio_ram_din", 32'(ram_din), 32'h11);
        tick();
        gb_set(1'b1, 1'b0, 15'h0010, 8'h00);
        save_clr = 1'b1;
        @(negedge clk);
        chk("prio_host_blocked", 32'(ram_we), 32'd0);
        tick();
        gb_set(1'b0, 1'b0, '0, '0);
        save_clr = 1'b0;
        @(negedge clk);
        chk("prio_gb_readback", 32'(ram_dout), 32'h11);
        chk("prio_host_issue", 32'(ram_din), 32'h22);
        chk("prio_dirty_cleared", 32'(dirty), 32'd0);
        host_finish(n + 3);
        tick(); n = cyc;
        host_start(1'b0, 15'h0010, 8'h00, 8'h22, 1'b1);
        host_finish(n + 1);

        // autosave after a single write
        tick(); n = cyc; p0 = pulses;
        gb_set(1'b0, 1'b1, 15'h0200, 8'h77);
        save_q.push_back(n + 9);
        tick();
        gb_set(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("auto_dirty", 32'(dirty), 32'd1);
        repeat (20) tick();
        chk("auto_single_pulse", 32'(pulses - p0), 32'd1);

        // second write at +5 restarts the quiet count
        tick(); n = cyc; p0 = pulses;
        gb_set(1'b0, 1'b1, 15'h0201, 8'h78);
        tick();
        gb_set(1'b0, 1'b0, '0, '0);
        repeat (4) tick();
        gb_set(1'b0, 1'b1, 15'h0202, 8'h79);
        save_q.push_back(n + 14);
        tick();
        gb_set(1'b0, 1'b0, '0, '0);
        repeat (20) tick();
        chk("auto_restart_pulse", 32'(pulses - p0), 32'd1);

        // save_clr together with a write: write wins and the timer restarts
        tick(); n = cyc; p0 = pulses;
        gb_set(1'b0, 1'b1, 15'h0203, 8'h7A);
        tick();
        gb_set(1'b0, 1'b0, '0, '0);
        repeat (2) tick();
        gb_set(1'b0, 1'b1, 15'h0204, 8'h7B);
        save_clr = 1'b1;
        save_q.push_back(n + 12);
        tick();
        gb_set(1'b0, 1'b0, '0, '0);
        save_clr = 1'b0;
        @(negedge clk);
        chk("clr_wr_dirty", 32'(dirty), 32'd1);
        repeat (20) tick();
        chk("clr_wr_pulse", 32'(pulses - p0), 32'd1);

        // save_clr alone cancels the pending autosave
        tick(); p0 = pulses;
        gb_set(1'b0, 1'b1, 15'h0205, 8'h7C);
        tick();
        gb_set(1'b0, 1'b0, '0, '0);
        repeat (2) tick();
        save_clr = 1'b1;
        tick();
        save_clr = 1'b0;
        @(negedge clk);
        chk("clr_dirty", 32'(dirty), 32'd0);
        repeat (20) tick();
        chk("clr_no_pulse", 32'(pulses - p0), 32'd0);

        // reset in WAIT abandons the read without an ack
        tick();
        gb_set(1'b0, 1'b1, 15'h0206, 8'h7D);
        tick();
        gb_set(1'b0, 1'b0, '0, '0);
        tick();
        host_start(1'b0, 15'h0123, 8'h00, 8'hA5, 1'b0);
        tick();
        chk("rst_pre_ack", 32'(host_ack), 32'd1);
        rst = 1'b1;
        host_req = 1'b0;
        #1;
        chk("rst_ack", 32'(host_ack), 32'd0);
        chk("rst_rdata", 32'(host_rdata), 32'd0);
        chk("rst_dirty", 32'(dirty), 32'd0);
        chk("rst_save_req", 32'(save_req), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        last_read = 8'h00;
        repeat (2) tick();
        rst = 1'b0;
        tick(); n = cyc;
        host_start(1'b0, 15'h0123, 8'h00, 8'hA5, 1'b1);
        host_finish(n + 1);

        repeat (3) tick();
        chk("host_queue_empty", 32'(host_q.size()), 32'd0);
        chk("save_queue_empty", 32'(save_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cart_ram_arbiter.md
Name: cart_ram_arbiter

Overview:
- Shares the single-port cartridge save RAM between the Game Boy cartridge bus (MBC5-decoded) and a host save/load port.
- The Game Boy always has priority and is never stalled. The host is served only in cycles where the Game Boy is not touching RAM.
- Tracks unsaved Game Boy writes and raises an autosave request after a quiet period.
- Sits between the core/MBC5 and the cartridge RAM instance, clocked by clk_gb.

Parameters:
- ABITS, 15, RAM address width (32768 words).
- IDLE_CYCLES, 1048576, quiet cycles after the last Game Boy write before save_req fires; must be ≥1.
- TW, 24, width of the quiet timer; must satisfy 2^TW > IDLE_CYCLES.

Ports:
- clk  in  1  system clock (clk_gb domain).
- rst  in  1  reset; asynchronous, active-high.
- gb_ram_cs_n  in  1  MBC5 RAM chip-select, active-low.
- gb_rd  in  1  Game Boy read strobe.
- gb_wr  in  1  Game Boy write strobe.
- gb_addr  in  ABITS  Game Boy RAM address (bank plus offset).
- gb_wdata  in  8  Game Boy write data.
- host_req  in  1  host request; level, held until host_ack.
- host_we  in  1  host write(1)/read(0); stable while host_req is high.
- host_addr  in  ABITS  host address; stable while host_req is high.
- host_wdata  in  8  host write data; stable while host_req is high.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  8  read data; valid on host_ack, then held.
- save_clr  in  1  pulse: host has finished a save, clear dirty.
- dirty  out  1  Game Boy has written since the last save_clr.
- save_req  out  1  one-cycle autosave request pulse.
- ram_addr  out  ABITS  RAM address.
- ram_din  out  8  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_dout  in  8  RAM read data; synchronous, 1-cycle latency.

Behaviour:
- gb_act = !gb_ram_cs_n & (gb_rd | gb_wr).
- RAM mux is combinational:
  - gb_act → ram_addr = gb_addr, ram_din = gb_wdata, ram_we = gb_wr.
  - else if host_issue → host_addr, host_wdata, ram_we = host_we.
  - else ram_addr = host_addr, ram_we = 0.
- Game Boy read data reaches the core on ram_dout one cycle later, unchanged from direct connection. The block adds no latency to the Game Boy path.
- Host FSM states: IDLE, WAIT.
  - IDLE: host_issue = host_req & !gb_act & !ack_hold. If host_issue, go to WAIT. If host_req & gb_act, stay in IDLE and retry next cycle.
  - WAIT: host_rdata <= ram_dout on reads (host_rdata unchanged on writes); host_ack = 1; go to IDLE.
  - ack_hold is set for the cycle after host_ack. It blocks reissue while the host drops host_req.
  - Latency with no contention: request cycle + 1, so host_ack is asserted in cycle N+1.
  - A Game Boy access arriving during WAIT does not disturb the capture, because ram_dout reflects the address from cycle N.
- Dirty and autosave:
  - gb_act & gb_wr sets dirty and loads timer = 0.
  - While dirty and timer < IDLE_CYCLES, the timer increments each cycle.
  - The timer is held at IDLE_CYCLES once reached, and save_req pulses exactly on the transition into IDLE_CYCLES.
  - save_clr clears dirty and the timer.
  - save_clr and a Game Boy write in the same cycle: the write wins, so dirty = 1 and timer = 0.
  - No further save_req is issued until a new Game Boy write occurs.
- Reset values: host_ack = 0, host_rdata = 0, dirty = 0, save_req = 0, FSM in IDLE, timer = 0, ack_hold = 0.
- Reset mid-transaction abandons it with no ack; the host must re-request.
- Host writes never set dirty.
- host_req dropped before ack is illegal; the bench asserts this.

Decomposition:
- Shared package: state enumeration (IDLE, WAIT) and default IDLE_CYCLES constant.
- One natural sub-module: save_idle_timer (dirty flag, quiet counter, save_req pulse), instantiated once.
- Arbiter mux and FSM stay in the top module.

Test Plan:
- Host read without contention: preload addr 0x0123 = 0xA5; host_req read 0x0123 → ram_we = 0, host_ack in cycle N+1, host_rdata = 0xA5.
- Contention: gb_rd active on cycles N..N+3 while host writes 0x5A to 0x0040 → no host ram_we during N..N+3; write issued at N+4, ack at N+5; Game Boy reads see correct data throughout.
- Game Boy write priority: gb_wr addr 0x0010 = 0x11 in the same cycle as host write addr 0x0010 = 0x22 → cycle-after readback 0x11; after host ack, final value 0x22.
- Autosave with IDLE_CYCLES = 8: single gb_wr → dirty = 1; save_req pulses exactly 8 cycles later, once. A second gb_wr at cycle 5 restarts the count.
- save_clr in the same cycle as gb_wr → dirty stays 1, timer restarts. save_clr alone → dirty = 0 and no save_req follows.
- Assert rst during WAIT → host_ack never pulses, all outputs return to reset values immediately; a re-request completes normally.
